fir_mac_scheduler: RTL and testbench

Time-multiplexed 8-tap FIR engine. One shared signed multiply-accumulate unit is sequenced across all taps, with run-time programmable Q1.15 coefficients. It sits between a sample source and sink with valid/ready handshakes on both sides. It trades throughput (one sample per 10 cycles minimum) for a single multiplier in place of eight parallel ones.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_mac.sv | 28 ++
 rtl/fir_mac_scheduler.sv | 128 ++++++++++++
 tb/tb_fir_mac_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR engine.
// The widths here are the defaults for the scheduler and its MAC unit.
package fir_pkg;
   localparam int TAPS    = 8;
   localparam int DW      = 16;
   localparam int AW      = 40;
   localparam int KW      = $clog2(TAPS);
   localparam int OUT_MSB = 30;
   localparam int OUT_LSB = 15;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_t;
endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate unit shared by all taps.
// The sum output shows acc plus the current product, before it is registered.
module fir_mac
   import fir_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [AW-1:0] acc,
   output logic signed [AW-1:0] sum
);
   logic signed [2*DW-1:0] prod;

   assign prod = a * b;
   assign sum  = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= sum;
   end
endmodule

// File: rtl/fir_mac_scheduler.sv
// Sequences one shared MAC across TAPS delay-line taps, one tap per cycle.
// Valid/ready handshakes on both sides; coefficients are writable only while idle.
module fir_mac_scheduler
   import fir_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] data_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] data_out,
   input  logic          cfg_we,
   input  logic [KW-1:0] cfg_addr,
   input  logic [DW-1:0] cfg_data,
   output logic          cfg_ready,
   output logic          busy
);
   state_t                state_reg, state_next;
   logic [KW-1:0]         k_reg;
   logic signed [DW-1:0]  x_reg [TAPS];
   logic signed [DW-1:0]  c_reg [TAPS];
   logic                  out_valid_reg;
   logic [DW-1:0]         data_out_reg;
   logic                  mac_clr, mac_en;
   logic signed [AW-1:0]  acc, sum;
   logic                  idle, accept, cfg_wr, last_tap;
   logic                  unused_bits;

   assign idle      = (state_reg == IDLE);
   assign accept    = idle && in_valid && !flush;
   assign cfg_wr    = idle && cfg_we && !flush;
   assign last_tap  = (k_reg == KW'(TAPS-1));

   assign in_ready  = idle;
   assign cfg_ready = idle;
   assign busy      = !idle;
   assign out_valid = out_valid_reg;
   assign data_out  = data_out_reg;

   // Only the Q1.15 window of the final sum is presented; the rest is dropped by design.
   assign unused_bits = ^{acc, sum[AW-1:OUT_MSB+1], sum[OUT_LSB-1:0]};

   fir_mac u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (x_reg[k_reg]),
      .b     (c_reg[k_reg]),
      .acc   (acc),
      .sum   (sum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = MAC;
               mac_clr    = 1'b1;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (last_tap)
               state_next = OUT;
         end
         OUT: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Abort wins over every other action in the same cycle.
      if (flush) begin
         state_next = IDLE;
         mac_clr    = 1'b1;
         mac_en     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            x_reg[i] <= '0;
            c_reg[i] <= '0;
         end
         k_reg         <= '0;
         out_valid_reg <= 1'b0;
         data_out_reg  <= '0;
      end else if (flush) begin
         for (int i = 0; i < TAPS; i++)
            x_reg[i] <= '0;
         k_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (cfg_wr)
            c_reg[cfg_addr] <= cfg_data;
         if (accept) begin
            x_reg[0] <= data_in;
            for (int i = 1; i < TAPS; i++)
               x_reg[i] <= x_reg[i-1];
            k_reg <= '0;
         end
         if (state_reg == MAC) begin
            k_reg <= k_reg + KW'(1);
            if (last_tap) begin
               data_out_reg  <= sum[OUT_MSB:OUT_LSB];
               out_valid_reg <= 1'b1;
            end
         end
         if (state_reg == OUT && out_ready)
            out_valid_reg <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench: directed cases with literal results plus randomized traffic
// checked against an arithmetic model of the filter (history array times coefficients).
module tb_fir_mac_scheduler;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] data_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] data_out;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic        cfg_ready;
   logic        busy;

   int checks = 0;
   int fails  = 0;

   logic signed [15:0] m_x [8];
   logic signed [15:0] m_c [8];
   logic [15:0]        exp_q [$];

   fir_mac_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      fails++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Filter output straight from the definition: sum of x[k]*c[k], then bits 30:15.
   function automatic logic [15:0] model_out();
      longint     s;
      logic [63:0] v;
      s = 0;
      for (int k = 0; k < 8; k++)
         s += longint'(m_x[k]) * longint'(m_c[k]);
      v = s;
      return v[30:15];
   endfunction

   function automatic void model_clear_history();
      for (int k = 0; k < 8; k++)
         m_x[k] = '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      m_c[addr] = data;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic accept(input logic [15:0] s);
      int n;
      in_valid = 1'b1;
      data_in  = s;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready)
         timeout_fail("accept_wait");
      for (int k = 7; k > 0; k--)
         m_x[k] = m_x[k-1];
      m_x[0] = s;
      exp_q.push_back(model_out());
      tick();
      in_valid = 1'b0;
      cfg_we   = 1'b0;
   endtask

   task automatic run_sample(input logic [15:0] s, input int hold, input bit bp_cfg,
                             output logic [15:0] got, output int lat);
      out_ready = (hold == 0);
      accept(s);
      lat = 0;
      while (!out_valid && lat < 30) begin
         tick();
         lat++;
      end
      if (!out_valid)
         timeout_fail("out_valid_wait");
      got = data_out;
      for (int h = 0; h < hold; h++) begin
         if (bp_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'd0;
            cfg_data = 16'h7FFF;
         end
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_stable", {16'd0, data_out}, {16'd0, got});
         tick();
      end
      cfg_we    = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   // Compare process: every cycle outside reset, check handshake decodes and the result.
   always @(negedge clk) begin
      if (!reset) begin
         check("in_ready_idle", {31'd0, in_ready}, {31'd0, !busy});
         check("cfg_ready_idle", {31'd0, cfg_ready}, {31'd0, in_ready});
         if (out_valid) begin
            check("in_ready_out", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0)
               timeout_fail("unexpected_out_valid");
            else begin
               check("data_out", {16'd0, data_out}, {16'd0, exp_q[0]});
               if (out_ready)
                  void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [15:0] got;
      int          lat;
      logic [15:0] impulse_exp [8];
      impulse_exp = '{16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00,
                      16'hFB00, 16'hFA00, 16'hF900, 16'hF800};
      model_clear_history();
      for (int k = 0; k < 8; k++)
         m_c[k] = '0;

      // Reset state
      repeat (3) tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      tick();
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("idle_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("idle_data_out", {16'd0, data_out}, 32'h0000);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Gain with latency
      cfg_write(3'd0, 16'h4000);
      run_sample(16'h4000, 0, 1'b0, got, lat);
      check("gain_value", {16'd0, got}, 32'h2000);
      check("gain_latency", lat, 8);

      // Coefficient write and accept in the same idle cycle
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h2000; m_c[0] = 16'h2000;
      run_sample(16'h4000, 0, 1'b0, got, lat);
      check("same_cycle_cfg", {16'd0, got}, 32'h1000);
      cfg_write(3'd0, 16'h4000);

      // Backpressure with dropped coefficient write, then gain readback
      run_sample(16'h4000, 5, 1'b1, got, lat);
      check("bp_value", {16'd0, got}, 32'h2000);
      run_sample(16'h4000, 0, 1'b0, got, lat);
      check("bp_cfg_dropped", {16'd0, got}, 32'h2000);

      // Idle flush to clear history, then impulse response
      flush = 1'b1; tick(); flush = 1'b0;
      model_clear_history();
      for (int k = 0; k < 8; k++)
         cfg_write(3'(k), 16'(16'h0100 * (k + 1)));
      for (int n = 0; n < 8; n++) begin
         run_sample((n == 0) ? 16'h8000 : 16'h0000, 0, 1'b0, got, lat);
         check("impulse", {16'd0, got}, {16'd0, impulse_exp[n]});
      end

      // Flush at the 4th MAC cycle
      cfg_write(3'd0, 16'h4000);
      for (int k = 1; k < 8; k++)
         cfg_write(3'(k), 16'h0000);
      accept(16'h1234);
      void'(exp_q.pop_back());
      repeat (3) tick();
      flush = 1'b1; tick(); flush = 1'b0;
      model_clear_history();
      for (int i = 0; i < 12; i++) begin
         check("flush_no_valid", {31'd0, out_valid}, 32'd0);
         check("flush_idle", {31'd0, busy}, 32'd0);
         tick();
      end
      run_sample(16'h4000, 0, 1'b0, got, lat);
      check("flush_gain", {16'd0, got}, 32'h2000);

      // Wrap: full history of 7FFF with all coefficients 7FFF
      for (int k = 0; k < 8; k++)
         cfg_write(3'(k), 16'h7FFF);
      for (int n = 0; n < 9; n++) begin
         run_sample(16'h7FFF, 0, 1'b0, got, lat);
         if (n >= 7)
            check("wrap", {16'd0, got}, 32'hFFF0);
      end

      // Asynchronous reset mid-MAC
      accept(16'h5555);
      void'(exp_q.pop_back());
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_data_out", {16'd0, data_out}, 32'h0000);
      model_clear_history();
      for (int k = 0; k < 8; k++)
         m_c[k] = '0;
      tick();
      reset = 1'b0;
      tick();
      run_sample(16'h7FFF, 0, 1'b0, got, lat);
      check("arst_coef_zero", {16'd0, got}, 32'h0000);

      // Randomized traffic with random coefficients and backpressure
      for (int it = 0; it < 40; it++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++)
            cfg_write(3'($urandom_range(0, 7)), 16'($urandom));
         run_sample(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got, lat);
         check("rand_latency", lat, 8);
      end

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
